// File: rtl/hazard_stall_unit_pkg.sv
// Shared encodings and source-use decode for the ID-stage hazard/stall unit.
package hazard_stall_unit_pkg;

   localparam logic [5:0] OP_R   = 6'h00;
   localparam logic [5:0] OP_J   = 6'h02;
   localparam logic [5:0] OP_JAL = 6'h03;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_BNE = 6'h05;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2b;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_SRA = 6'h03;
   localparam logic [5:0] FN_JR  = 6'h08;

   typedef enum logic [1:0] {
      JB_NONE   = 2'b00,
      JB_BRANCH = 2'b01,
      JB_JUMP   = 2'b10,
      JB_RSVD   = 2'b11
   } jb_flag_e;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'b00,
      CAUSE_LOAD_USE = 2'b01,
      CAUSE_BR_OPND  = 2'b10,
      CAUSE_BR_LOAD  = 2'b11
   } stall_cause_e;

   typedef struct packed {
      logic [4:0] dst;
      logic       wr;
      logic       ld;
   } shadow_t;

   // Decoded from raw opcode/funct only, so nothing here depends on ctl_mux.
   function automatic logic rs_used(input logic [5:0] op, input logic [5:0] funct);
      logic shift_imm;
      shift_imm = (op == OP_R) && (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA);
      return !(op == OP_J || op == OP_JAL || shift_imm);
   endfunction

   function automatic logic rt_used(input logic [5:0] op, input logic [5:0] funct);
      return ((op == OP_R) && (funct != FN_JR)) || op == OP_BEQ || op == OP_BNE || op == OP_SW;
   endfunction

   function automatic logic is_branch(input logic [5:0] op, input logic [5:0] funct);
      return op == OP_BEQ || op == OP_BNE || ((op == OP_R) && (funct == FN_JR));
   endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// ID-stage fields in, pipeline-control signals out.
interface hazard_stall_unit_if;
   logic [5:0] id_op;
   logic [5:0] id_funct;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic [4:0] id_rd;
   logic       id_reg_write;
   logic       id_mem_to_reg;
   logic       id_reg_dst;
   logic       id_link;
   logic [1:0] jb_flag;
   logic       ctl_mux;
   logic       pc_write;
   logic       ifid_write;
   logic       if_flush;
   logic [1:0] stall_cause;

   modport master (
      output id_op, id_funct, id_rs, id_rt, id_rd,
             id_reg_write, id_mem_to_reg, id_reg_dst, id_link, jb_flag,
      input  ctl_mux, pc_write, ifid_write, if_flush, stall_cause
   );

   modport slave (
      input  id_op, id_funct, id_rs, id_rt, id_rd,
             id_reg_write, id_mem_to_reg, id_reg_dst, id_link, jb_flag,
      output ctl_mux, pc_write, ifid_write, if_flush, stall_cause
   );
endinterface

// File: rtl/hazard_shadow_pipe.sv
// Shadow EX/MEM destination state; a bubble loads zeros into EX.
// One-cycle register per stage, no backpressure.
module hazard_shadow_pipe
   import hazard_stall_unit_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   input  logic    bubble,
   input  shadow_t id_sh,
   output shadow_t ex_sh,
   output shadow_t mem_sh
);

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_sh  <= '0;
         mem_sh <= '0;
      end else begin
         ex_sh  <= bubble ? shadow_t'('0) : id_sh;
         mem_sh <= ex_sh;
      end
   end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use / branch-operand stall detection and jump/branch flush control.
// Outputs are zero-latency combinational; stalling is how it throttles fetch.
module hazard_stall_unit
   import hazard_stall_unit_pkg::*;
#(
   parameter int         CNT_W    = 16,
   parameter logic [4:0] LINK_REG = 5'd31
) (
   input  logic                 clk,
   input  logic                 reset,
   hazard_stall_unit_if.slave   hz,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   shadow_t      id_sh, ex_sh, mem_sh;
   logic         rs_use, rt_use, is_br;
   logic         ex_hit, mem_hit, stall;
   stall_cause_e cause;

   always_comb begin
      id_sh.dst = hz.id_reg_dst ? hz.id_rd : (hz.id_link ? LINK_REG : hz.id_rt);
      id_sh.wr  = hz.id_reg_write;
      id_sh.ld  = hz.id_mem_to_reg;
   end

   hazard_shadow_pipe u_shadow (
      .clk    (clk),
      .reset  (reset),
      .bubble (hz.ctl_mux),
      .id_sh  (id_sh),
      .ex_sh  (ex_sh),
      .mem_sh (mem_sh)
   );

   assign rs_use = rs_used(hz.id_op, hz.id_funct);
   assign rt_use = rt_used(hz.id_op, hz.id_funct);
   assign is_br  = is_branch(hz.id_op, hz.id_funct);

   // A zero destination can never match, which also covers $0 sources.
   assign ex_hit  = ex_sh.wr && (ex_sh.dst != 5'd0) &&
                    ((rs_use && ex_sh.dst == hz.id_rs) || (rt_use && ex_sh.dst == hz.id_rt));
   assign mem_hit = mem_sh.wr && (mem_sh.dst != 5'd0) &&
                    ((rs_use && mem_sh.dst == hz.id_rs) || (rt_use && mem_sh.dst == hz.id_rt));

   always_comb begin
      cause = CAUSE_NONE;
      if (is_br && ex_hit && ex_sh.ld)
         cause = CAUSE_BR_LOAD;
      else if (is_br && (ex_hit || (mem_hit && mem_sh.ld)))
         cause = CAUSE_BR_OPND;
      else if (!is_br && ex_hit && ex_sh.ld)
         cause = CAUSE_LOAD_USE;
   end

   assign stall = (cause != CAUSE_NONE);

   always_comb begin
      hz.ctl_mux     = 1'b0;
      hz.pc_write    = 1'b1;
      hz.ifid_write  = 1'b1;
      hz.if_flush    = (hz.jb_flag != JB_NONE);
      hz.stall_cause = cause;
      if (reset) begin
         hz.ctl_mux     = 1'b1;
         hz.pc_write    = 1'b0;
         hz.ifid_write  = 1'b0;
         hz.if_flush    = 1'b1;
         hz.stall_cause = CAUSE_NONE;
      end else if (stall) begin
         // Operands are stale while stalled, so the jump/branch decision waits.
         hz.ctl_mux    = 1'b1;
         hz.pc_write   = 1'b0;
         hz.ifid_write = 1'b0;
         hz.if_flush   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_ONE;
         if (hz.if_flush && flush_cnt != '1)
            flush_cnt <= flush_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Cycle-vector bench for hazard_stall_unit with a scoreboard queue and a counter model.
module tb_hazard_stall_unit;
   import hazard_stall_unit_pkg::*;

   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             clk = 1'b0;
   logic             reset;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   hazard_stall_unit_if bus ();

   hazard_stall_unit #(.CNT_W(CNT_W), .LINK_REG(5'd31)) dut (
      .clk       (clk),
      .reset     (reset),
      .hz        (bus),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] op, funct;
      logic [4:0] rs, rt, rd;
      logic       rw, m2r, rdst, link;
   } ins_t;

   typedef struct {
      logic       rst;
      ins_t       ins;
      logic [1:0] jb;
      logic       ctl, pcw, ifw, fl;
      logic [1:0] cause;
   } vec_t;

   typedef struct {
      logic             ctl, pcw, ifw, fl;
      logic [1:0]       cause;
      logic             cnt_ok;
      logic [CNT_W-1:0] scnt, fcnt;
   } exp_t;

   vec_t             tbl[$];
   exp_t             sb[$];
   int               n_cmp  = 0;
   int               n_fail = 0;
   int               cyc    = 0;
   logic             model_valid = 1'b0;
   logic [CNT_W-1:0] m_scnt = '0;
   logic [CNT_W-1:0] m_fcnt = '0;

   function automatic ins_t mk(input logic [5:0] op, input logic [5:0] funct,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic rw, input logic m2r, input logic rdst, input logic link);
      ins_t i;
      i.op = op; i.funct = funct; i.rs = rs; i.rt = rt; i.rd = rd;
      i.rw = rw; i.m2r = m2r; i.rdst = rdst; i.link = link;
      return i;
   endfunction

   function automatic ins_t i_lw(input logic [4:0] rt, input logic [4:0] rs);
      return mk(OP_LW, 6'h00, rs, rt, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
   endfunction
   function automatic ins_t i_sw(input logic [4:0] rt, input logic [4:0] rs);
      return mk(OP_SW, 6'h00, rs, rt, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction
   function automatic ins_t i_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
      return mk(OP_R, 6'h20, rs, rt, rd, 1'b1, 1'b0, 1'b1, 1'b0);
   endfunction
   function automatic ins_t i_sll(input logic [4:0] rd, input logic [4:0] rt, input logic [4:0] rs_field);
      return mk(OP_R, FN_SLL, rs_field, rt, rd, 1'b1, 1'b0, 1'b1, 1'b0);
   endfunction
   function automatic ins_t i_br(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
      return mk(op, 6'h00, rs, rt, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction
   function automatic ins_t i_jal();
      return mk(OP_JAL, 6'h00, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
   endfunction
   function automatic ins_t i_jr(input logic [4:0] rs);
      return mk(OP_R, FN_JR, rs, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction
   function automatic ins_t i_nop();
      return mk(OP_R, FN_SLL, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
   endfunction

   function automatic vec_t mkv(input logic rst, input ins_t ins, input logic [1:0] jb,
                                input logic ctl, input logic pcw, input logic ifw,
                                input logic fl, input logic [1:0] cause);
      vec_t v;
      v.rst = rst; v.ins = ins; v.jb = jb;
      v.ctl = ctl; v.pcw = pcw; v.ifw = ifw; v.fl = fl; v.cause = cause;
      return v;
   endfunction

   // Shorthands: normal flow with explicit flush, a stall with explicit cause, a reset cycle.
   task automatic t_run(input ins_t ins, input logic [1:0] jb, input logic fl);
      tbl.push_back(mkv(1'b0, ins, jb, 1'b0, 1'b1, 1'b1, fl, 2'b00));
   endtask
   task automatic t_stall(input ins_t ins, input logic [1:0] jb, input logic [1:0] cause);
      tbl.push_back(mkv(1'b0, ins, jb, 1'b1, 1'b0, 1'b0, 1'b0, cause));
   endtask
   task automatic t_rst(input ins_t ins);
      tbl.push_back(mkv(1'b1, ins, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00));
   endtask

   task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL cycle %0d %s: got %0h expected %0h", cyc, name, act, exp);
      end
   endtask

   task automatic check_out();
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL cycle %0d scoreboard: got empty queue expected an entry", cyc);
         return;
      end
      e = sb.pop_front();
      cmp("ctl_mux",     {7'd0, bus.ctl_mux},     {7'd0, e.ctl});
      cmp("pc_write",    {7'd0, bus.pc_write},    {7'd0, e.pcw});
      cmp("ifid_write",  {7'd0, bus.ifid_write},  {7'd0, e.ifw});
      cmp("if_flush",    {7'd0, bus.if_flush},    {7'd0, e.fl});
      cmp("stall_cause", {6'd0, bus.stall_cause}, {6'd0, e.cause});
      if (e.cnt_ok) begin
         cmp("stall_cnt", {4'd0, stall_cnt}, {4'd0, e.scnt});
         cmp("flush_cnt", {4'd0, flush_cnt}, {4'd0, e.fcnt});
      end
   endtask

   task automatic apply(input vec_t v);
      exp_t e;
      reset             = v.rst;
      bus.id_op         = v.ins.op;
      bus.id_funct      = v.ins.funct;
      bus.id_rs         = v.ins.rs;
      bus.id_rt         = v.ins.rt;
      bus.id_rd         = v.ins.rd;
      bus.id_reg_write  = v.ins.rw;
      bus.id_mem_to_reg = v.ins.m2r;
      bus.id_reg_dst    = v.ins.rdst;
      bus.id_link       = v.ins.link;
      bus.jb_flag       = v.jb;
      e.ctl = v.ctl; e.pcw = v.pcw; e.ifw = v.ifw; e.fl = v.fl; e.cause = v.cause;
      e.cnt_ok = model_valid; e.scnt = m_scnt; e.fcnt = m_fcnt;
      sb.push_back(e);
      @(negedge clk);
      check_out();
      @(posedge clk);
      if (v.rst) begin
         m_scnt = '0;
         m_fcnt = '0;
         model_valid = 1'b1;
      end else begin
         if (v.cause != 2'b00 && m_scnt != CNT_MAX) m_scnt = m_scnt + 1'b1;
         if (v.fl && m_fcnt != CNT_MAX) m_fcnt = m_fcnt + 1'b1;
      end
      cyc++;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of test expected finish within 100000 time units");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset state
      t_rst(i_nop());
      t_rst(i_nop());
      // load-use
      t_run(i_lw(5'd2, 5'd1), 2'b00, 1'b0);
      t_stall(i_add(5'd3, 5'd2, 5'd4), 2'b00, 2'b01);
      t_run(i_add(5'd3, 5'd2, 5'd4), 2'b00, 1'b0);
      // branch after ALU
      t_run(i_add(5'd5, 5'd6, 5'd7), 2'b00, 1'b0);
      t_stall(i_br(OP_BEQ, 5'd5, 5'd0), 2'b00, 2'b10);
      t_run(i_br(OP_BEQ, 5'd5, 5'd0), 2'b01, 1'b1);
      // branch after load
      t_run(i_lw(5'd8, 5'd9), 2'b00, 1'b0);
      t_stall(i_br(OP_BNE, 5'd8, 5'd1), 2'b01, 2'b11);
      t_stall(i_br(OP_BNE, 5'd8, 5'd1), 2'b01, 2'b10);
      t_run(i_br(OP_BNE, 5'd8, 5'd1), 2'b01, 1'b1);
      // no false hazards
      t_run(i_lw(5'd5, 5'd1), 2'b00, 1'b0);
      t_run(i_sll(5'd2, 5'd3, 5'd5), 2'b00, 1'b0);
      t_run(i_lw(5'd0, 5'd1), 2'b00, 1'b0);
      t_run(i_add(5'd3, 5'd0, 5'd0), 2'b00, 1'b0);
      t_run(i_jal(), 2'b10, 1'b1);
      t_run(i_nop(), 2'b00, 1'b0);
      t_run(i_jr(5'd31), 2'b10, 1'b1);
      // stall beats a forced jump
      t_run(i_add(5'd4, 5'd1, 5'd2), 2'b00, 1'b0);
      t_stall(i_jr(5'd4), 2'b10, 2'b10);
      t_run(i_jr(5'd4), 2'b10, 1'b1);
      // reset during the cause-11 cycle
      t_run(i_lw(5'd8, 5'd9), 2'b00, 1'b0);
      t_rst(i_br(OP_BNE, 5'd8, 5'd1));
      t_run(i_add(5'd10, 5'd11, 5'd12), 2'b00, 1'b0);
      t_run(i_add(5'd13, 5'd10, 5'd1), 2'b00, 1'b0);
      // store data operand and reserved jb encoding
      t_run(i_lw(5'd6, 5'd7), 2'b00, 1'b0);
      t_stall(i_sw(5'd6, 5'd7), 2'b00, 2'b01);
      t_run(i_sw(5'd6, 5'd7), 2'b00, 1'b0);
      t_run(i_nop(), 2'b11, 1'b1);

      foreach (tbl[i]) apply(tbl[i]);

      // stall counter saturation
      for (int k = 0; k < 17; k++) begin
         apply(mkv(1'b0, i_lw(5'd2, 5'd1), 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00));
         apply(mkv(1'b0, i_add(5'd3, 5'd2, 5'd4), 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01));
      end
      // flush counter saturation
      for (int k = 0; k < 20; k++)
         apply(mkv(1'b0, i_nop(), 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00));
      apply(mkv(1'b0, i_nop(), 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00));
      // reset clears saturated counters
      apply(mkv(1'b1, i_nop(), 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00));
      apply(mkv(1'b0, i_nop(), 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Produces the pipeline-control signals consumed by the ID-stage control decoder and the fetch path: ctl_mux (bubble insert), pc_write, ifid_write, if_flush.
- Keeps its own shadow copy of the EX and MEM destination/write state. It detects load-use hazards and ID-stage branch/jr operand hazards, and converts jump/branch decisions into IF/ID flushes.
- Sits beside the ID stage; its inputs are the ID instruction fields, the decoder's write-back controls and jb_flag.

Parameters:
- CNT_W, 16, width of the saturating stall and flush event counters.
- LINK_REG, 31, destination register written by jal.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- id_op  in  6  opcode of the instruction in ID
- id_funct  in  6  funct field of the instruction in ID
- id_rs  in  5  rs field
- id_rt  in  5  rt field
- id_rd  in  5  rd field
- id_reg_write  in  1  decoder RegWrite for the ID instruction
- id_mem_to_reg  in  1  decoder MemtoReg (load)
- id_reg_dst  in  1  decoder RegDst
- id_link  in  1  jal link indication
- jb_flag  in  2  00 none, 01 branch taken, 10 jump/jr
- ctl_mux  out  1  1 = decoder emits all-zero controls (bubble)
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register enable
- if_flush  out  1  clear IF/ID to nop
- stall_cause  out  2  00 none, 01 load-use, 10 branch-operand, 11 branch-after-load
- stall_cnt  out  CNT_W  count of stalled cycles, saturating
- flush_cnt  out  CNT_W  count of flushes, saturating

Behaviour:
- Source use is decoded internally from id_op/id_funct only. It never uses decoder outputs, so no combinational loop with ctl_mux.
- rs is a source except for op J (000010), JAL (000011), and R-type funct sll/srl/sra (000000/000010/000011).
- rt is a source for R-type (except funct jr 001000), beq (000100), bne (000101) and sw (101011).
- A source equal to 0 never matches.
- ID destination = id_reg_dst ? id_rd : (id_link ? LINK_REG : id_rt).
- Shadow EX register {ex_dst, ex_wr, ex_ld} loads from ID every cycle: the ID values when ctl_mux=0, else all zero (bubble).
- Shadow MEM register {mem_dst, mem_wr, mem_ld} loads from shadow EX every cycle.
- "match X" means X_wr=1 && X_dst!=0 && X_dst equals a used source.
- is_br = op beq/bne, or R-type with funct jr.
- Stall conditions, checked in priority order:
  - is_br && match EX && ex_ld -> cause 11.
  - is_br && (match EX, or match MEM && mem_ld) -> cause 10.
  - !is_br && match EX && ex_ld -> cause 01.
  - Otherwise no stall, cause 00.
- Stall outputs: ctl_mux=1, pc_write=0, ifid_write=0, if_flush=0. jb_flag is ignored while stalled because the operands are stale.
- Branch after load stalls 2 cycles (cause 11 then 10). Branch after ALU stalls 1 cycle. Load-use stalls 1 cycle.
- No stall: ctl_mux=0, pc_write=1, ifid_write=1, if_flush=(jb_flag!=00).
- jb_flag=11 is treated as a flush.
- All outputs are combinational from the registered shadow state plus the ID inputs; zero-cycle latency.
- Counters: stall_cnt increments on each stalled cycle; flush_cnt increments on each if_flush cycle. Both hold at all-ones.
- Reset (synchronous):
  - shadow EX and MEM cleared, counters cleared.
  - While reset=1: ctl_mux=1, pc_write=0, ifid_write=0, if_flush=1, stall_cause=00; counters do not count.
  - Reset mid-stall drops the pending stall.

Decomposition:
- Shared package holds:
  - opcode constants: R, J, JAL, BEQ, BNE, SW, LW;
  - funct constants: JR, SLL, SRL, SRA;
  - jb_flag encodings;
  - stall_cause encodings.
- One natural sub-module, hazard_shadow_pipe: the shadow EX/MEM registers with bubble insertion.
- Matching, priority logic and counters stay in the top level.

Test Plan:
- Load-use: lw $2,0($1) then add $3,$2,$4. Expect 1 cycle of ctl_mux=1, pc_write=0, cause 01, then normal flow; stall_cnt=1.
- Branch after ALU: add $5,$6,$7 then beq $5,$0,L. Expect 1 stall with cause 10; on the following cycle jb_flag=01 gives if_flush=1 and flush_cnt=1.
- Branch after load: lw $8,4($9) then bne $8,$1,L. Expect 2 stalls (cause 11, then 10), then the branch resolves; stall_cnt=2.
- No false hazards:
  - sll $2,$3,4 following lw $5: no stall (rs unused).
  - lw $0,0($1) then add $3,$0,$0: no stall (dest 0).
  - jal then jr $31 two instructions later: no stall.
- Stall priority over jump: jr $4 immediately after add $4,... with jb_flag forced 10 during the stall. Expect if_flush=0 during the stall and 1 on the release cycle.
- Reset mid-stall: assert reset during the cause-11 cycle. Expect ctl_mux=1, if_flush=1, counters 0. After release, the next unrelated instruction shows no stall.
